// File: rtl/pretreat_feed_ctrl.sv
// -----------------------------------------------------------------------------
// pretreat_feed_ctrl
//
// Purpose
//   Streams one IMG_W x IMG_H greyscale frame from a pixel RAM into the
//   normalisation pipeline and forwards every pipeline result into a
//   downstream FIFO. Pixel issue is throttled by a credit rule so that the
//   FIFO can never overflow even though the pipeline has no backpressure.
//
// Ports
//   clk                 single clock, rising edge
//   rst_n               asynchronous active-low reset
//   start               one-cycle request for one frame (ignored unless idle)
//   busy / done         frame in progress / one-cycle completion pulse
//   err                 sticky protocol error (result with nothing in flight)
//   pix_rd_en/addr      pixel RAM read strobe and address (RAM latency 1)
//   pix_rd_data         pixel RAM read data
//   pre_data_in(_valid) pixel and its valid towards the pipeline
//   pre_data_out(_valid) Q6.10 result and its valid from the pipeline
//   fifo_wr_count       downstream FIFO occupancy
//   fifo_wr_en/fifo_din downstream FIFO write port
//   stall_cnt           cycles lost to credit stalls while feeding
//
// Build option
//   PRETREAT_STALL_CNT_EN  when defined, stall_cnt is a live saturating
//                          counter; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module pretreat_feed_ctrl #(
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 1024,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              pix_rd_en,
   output logic [ADDR_W-1:0] pix_rd_addr,
   input  logic [7:0]        pix_rd_data,
   output logic [7:0]        pre_data_in,
   output logic              pre_data_in_valid,
   input  logic [15:0]       pre_data_out,
   input  logic              pre_data_out_valid,
   input  logic [CNT_W-1:0]  fifo_wr_count,
   output logic              fifo_wr_en,
   output logic [15:0]       fifo_din,
   output logic [15:0]       stall_cnt
);

   localparam int N    = IMG_W * IMG_H;
   localparam int PC_W = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pix_cnt_q, pix_cnt_d;
   logic [PC_W-1:0]     out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]    inflight_q, inflight_d;
   logic                err_q, err_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                in_vld_q;

   logic                start_acc;
   logic [CNT_W:0]      credit_sum;
   logic                credit_ok;
   logic                issue;
   logic                last_issue;
   logic                spurious;

   // ---------------------------------------------------------------------------
   // Issue / credit decode
   // ---------------------------------------------------------------------------
   assign start_acc  = (state_q == IDLE) && start;
   // One extra bit so occupancy + in-flight cannot wrap before the compare.
   assign credit_sum = {1'b0, fifo_wr_count} + {1'b0, inflight_q};
   assign credit_ok  = (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
   assign issue      = (state_q == FEED) && credit_ok;
   assign last_issue = issue && (pix_cnt_q == PC_W'(N - 1));
   // A result with nothing outstanding cannot belong to this frame.
   assign spurious   = pre_data_out_valid && (inflight_q == '0);

   // ---------------------------------------------------------------------------
   // Counters and flags
   // ---------------------------------------------------------------------------
   always_comb begin
      pix_cnt_d  = pix_cnt_q;
      out_cnt_d  = out_cnt_q;
      inflight_d = inflight_q;
      err_d      = err_q;
      rd_en_d    = issue;
      rd_addr_d  = rd_addr_q;

      if (start_acc) begin
         pix_cnt_d = '0;
      end else if (issue) begin
         pix_cnt_d = pix_cnt_q + PC_W'(1);
      end

      if (issue) begin
         rd_addr_d = ADDR_W'(pix_cnt_q);
      end

      if (start_acc) begin
         out_cnt_d = '0;
      end else if (pre_data_out_valid) begin
         out_cnt_d = out_cnt_q + PC_W'(1);
      end

      // Issue and return in the same cycle cancel; a return with nothing
      // outstanding leaves the count pinned at zero.
      unique case ({issue, pre_data_out_valid})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = spurious ? inflight_q : (inflight_q - CNT_W'(1));
         default: inflight_d = inflight_q;
      endcase

      // A stray result in the same cycle as a new start is still reported.
      err_d = (start_acc ? 1'b0 : err_q) | spurious;
   end

   // ---------------------------------------------------------------------------
   // Frame FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = FEED;
         end
         FEED: begin
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            // Next-state values let DONE follow the final result by one cycle.
            if ((inflight_d == '0) && (out_cnt_d == PC_W'(N))) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pix_cnt_q  <= '0;
         out_cnt_q  <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         in_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_cnt_q  <= pix_cnt_d;
         out_cnt_q  <= out_cnt_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         // RAM answers one cycle after the strobe, so the valid trails it by one.
         in_vld_q   <= rd_en_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Credit-stall counter
   // ---------------------------------------------------------------------------
`ifdef PRETREAT_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (start_acc) begin
         stall_d = '0;
      end else if ((state_q == FEED) && !credit_ok && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign busy              = (state_q == FEED) || (state_q == DRAIN);
   assign done              = (state_q == DONE);
   assign err               = err_q;
   assign pix_rd_en         = rd_en_q;
   assign pix_rd_addr       = rd_addr_q;
   assign pre_data_in       = pix_rd_data;
   assign pre_data_in_valid = in_vld_q;
   // Results go straight to the FIFO in every state; credits bound occupancy.
   assign fifo_wr_en        = pre_data_out_valid;
   assign fifo_din          = pre_data_out;

endmodule

// File: tb/tb_pretreat_feed_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pretreat_feed_ctrl
//
// Bench for pretreat_feed_ctrl: models the pixel RAM (latency 1) and a
// fixed-latency normalisation pipeline, pushes the expected FIFO word for
// every observed RAM read into a scoreboard queue, and pops/compares in an
// independent monitor whenever the DUT writes the FIFO.
// Honours PRETREAT_STALL_CNT_EN for the stall counter expectation.
// -----------------------------------------------------------------------------
module tb_pretreat_feed_ctrl;

   localparam int IMG_W      = 28;
   localparam int IMG_H      = 28;
   localparam int ADDR_W     = 10;
   localparam int FIFO_DEPTH = 1024;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int N          = IMG_W * IMG_H;
   localparam int LAT        = 40;
`ifdef PRETREAT_STALL_CNT_EN
   localparam int STALL_EXP  = 10;
`else
   localparam int STALL_EXP  = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              busy, done, err;
   logic              pix_rd_en;
   logic [ADDR_W-1:0] pix_rd_addr;
   logic [7:0]        pix_rd_data;
   logic [7:0]        pre_data_in;
   logic              pre_data_in_valid;
   logic [15:0]       pre_data_out;
   logic              pre_data_out_valid;
   logic [CNT_W-1:0]  fifo_wr_count = '0;
   logic              fifo_wr_en;
   logic [15:0]       fifo_din;
   logic [15:0]       stall_cnt;

   logic              pipe_out_v;
   logic [15:0]       pipe_out_d;
   logic              inj = 1'b0;

   assign pre_data_out_valid = pipe_out_v | inj;
   assign pre_data_out       = pipe_out_d;

   always #5 clk = ~clk;

   pretreat_feed_ctrl #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .err(err),
      .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
      .pre_data_in(pre_data_in), .pre_data_in_valid(pre_data_in_valid),
      .pre_data_out(pre_data_out), .pre_data_out_valid(pre_data_out_valid),
      .fifo_wr_count(fifo_wr_count), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .stall_cnt(stall_cnt)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;
   int n_reads, n_wr, n_match, n_unexp, n_done;
   int first_rd_cyc, last_rd_cyc, last_wr_cyc, done_cyc, addr_at5, exp_addr, max_out;
   logic [15:0] sb[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ram_val(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h5C;
   endfunction

   function automatic logic [15:0] pipe_fn(input logic [7:0] p);
      return {~p, p};
   endfunction

   task automatic clear_stats();
      n_reads = 0; n_wr = 0; n_match = 0; n_unexp = 0; n_done = 0;
      first_rd_cyc = -1; last_rd_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
      addr_at5 = -1; exp_addr = 0; max_out = 0;
      sb.delete();
   endtask

   // RAM and pipeline model; also the scoreboard producer.
   logic              rd_en_s, in_v_s;
   logic [ADDR_W-1:0] rd_addr_s;
   logic [7:0]        in_d_s;
   logic              pv_q[LAT];
   logic [7:0]        pd_q[LAT];

   initial begin
      for (int i = 0; i < LAT; i++) begin pv_q[i] = 1'b0; pd_q[i] = 8'h00; end
      pix_rd_data = 8'h00; pipe_out_v = 1'b0; pipe_out_d = 16'h0000;
      forever begin
         @(posedge clk);
         rd_en_s = pix_rd_en; rd_addr_s = pix_rd_addr;
         in_v_s = pre_data_in_valid; in_d_s = pre_data_in;
         #1;
         if (rd_en_s) begin
            pix_rd_data = ram_val(rd_addr_s);
            n_reads++;
            if (n_reads == 1) first_rd_cyc = cyc;
            last_rd_cyc = cyc;
            if (n_reads == 5) addr_at5 = int'(rd_addr_s);
            chk("rd_addr", rd_addr_s, exp_addr);
            exp_addr++;
            sb.push_back(pipe_fn(ram_val(rd_addr_s)));
         end
         pipe_out_v = pv_q[LAT-1];
         pipe_out_d = pipe_fn(pd_q[LAT-1]);
         for (int i = LAT-1; i > 0; i--) begin pv_q[i] = pv_q[i-1]; pd_q[i] = pd_q[i-1]; end
         pv_q[0] = in_v_s; pd_q[0] = in_d_s;
      end
   end

   // Monitor: consumer side of the scoreboard.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (fifo_wr_en) begin
            n_wr++; last_wr_cyc = cyc;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("fifo_din", fifo_din, e);
               n_match++;
            end else begin
               n_unexp++;
            end
         end
         if (done) begin
            n_done++; done_cyc = cyc;
            chk("busy_with_done", busy, 0);
         end
         if (n_reads - n_wr > max_out) max_out = n_reads - n_wr;
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!(done === 1'b1) && k < budget) begin @(negedge clk); k++; end
      chk("done_seen", done === 1'b1, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_reads(input int target, input int budget);
      int k = 0;
      while (n_reads < target && k < budget) begin @(negedge clk); k++; end
      chk("reads_reached", n_reads >= target, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_stats();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rd_en", pix_rd_en, 0);
      chk("rst_rd_addr", pix_rd_addr, 0);
      chk("rst_in_valid", pre_data_in_valid, 0);
      chk("rst_stall", stall_cnt, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Scenario 1: free-running frame
      clear_stats();
      fifo_wr_count = '0;
      pulse_start();
      chk("s1_busy_after_start", busy, 1);
      wait_done(3000);
      chk("s1_reads", n_reads, N);
      chk("s1_consecutive", last_rd_cyc - first_rd_cyc, N - 1);
      chk("s1_writes", n_match, N);
      chk("s1_unexpected", n_unexp, 0);
      chk("s1_done_after_last", done_cyc - last_wr_cyc, 1);
      chk("s1_done_pulses", n_done, 1);
      chk("s1_err", err, 0);
      chk("s1_busy_idle", busy, 0);
      chk("s1_stall", stall_cnt, 0);

      // Scenario 2: credit stall then resume
      clear_stats();
      fifo_wr_count = CNT_W'(1020);
      pulse_start();
      repeat (20) @(negedge clk);
      chk("s2_reads_at_1020", n_reads, 4);
      chk("s2_out_at_1020", max_out, 4);
      max_out = 0;
      fifo_wr_count = CNT_W'(1000);
      wait_done(6000);
      chk("s2_resume_addr", addr_at5, 4);
      chk("s2_reads", n_reads, N);
      chk("s2_writes", n_match, N);
      chk("s2_no_overflow", max_out <= 24, 1);
      chk("s2_err", err, 0);
      fifo_wr_count = '0;

      // Scenario 3: start during a frame is ignored
      clear_stats();
      pulse_start();
      wait_reads(100, 500);
      pulse_start();
      wait_done(3000);
      repeat (5) @(negedge clk);
      chk("s3_reads", n_reads, N);
      chk("s3_writes", n_match, N);
      chk("s3_done_pulses", n_done, 1);
      chk("s3_err", err, 0);

      // Scenario 4: reset mid-frame, then a clean frame
      clear_stats();
      pulse_start();
      wait_reads(300, 1000);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("s4_rst_busy", busy, 0);
      chk("s4_rst_rd_en", pix_rd_en, 0);
      chk("s4_rst_rd_addr", pix_rd_addr, 0);
      chk("s4_rst_in_valid", pre_data_in_valid, 0);
      chk("s4_rst_done", done, 0);
      chk("s4_rst_err", err, 0);
      chk("s4_rst_stall", stall_cnt, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      n_unexp = 0;
      repeat (LAT + 10) @(negedge clk);
      chk("s4_leftovers_seen", n_unexp > 0, 1);
      chk("s4_leftover_err", err, 1);
      clear_stats();
      pulse_start();
      chk("s4_err_cleared", err, 0);
      wait_done(3000);
      chk("s4_reads", n_reads, N);
      chk("s4_writes", n_match, N);
      chk("s4_unexpected", n_unexp, 0);
      chk("s4_err", err, 0);

      // Scenario 5: stray result in IDLE
      clear_stats();
      @(posedge clk); #2;
      inj = 1'b1;
      #1;
      chk("s5_wr_en_passthru", fifo_wr_en, 1);
      @(posedge clk); #1;
      inj = 1'b0;
      chk("s5_err_set", err, 1);
      repeat (2) @(negedge clk);
      chk("s5_err_sticky", err, 1);
      pulse_start();
      chk("s5_err_cleared", err, 0);
      wait_done(3000);
      chk("s5_reads", n_reads, N);

      // Scenario 6: ten cycles of full FIFO during FEED
      clear_stats();
      pulse_start();
      wait_reads(200, 500);
      @(negedge clk);
      fifo_wr_count = CNT_W'(1024);
      repeat (10) @(negedge clk);
      fifo_wr_count = '0;
      wait_done(3000);
      chk("s6_stall_cnt", stall_cnt, STALL_EXP);
      chk("s6_reads", n_reads, N);
      chk("s6_writes", n_match, N);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
